// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider: FSM state encoding,
// default operand width and iteration-counter sizing.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Counter width for an arbitrary operand width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor cell: a - b - bin, producing difference and borrow-out.
module fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_CHECK_EN enables zero-divisor detection with an early done.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t     state;
    div_state_t     state_next;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    cnt;
    logic             zero_hit;

    logic [WIDTH:0]   s;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] bw;
    logic             unused_top_diff;

    // Trial subtraction S - {0, divisor} through the borrow-ripple chain.
    assign s     = {r_reg, dvd_reg[cnt]};
    assign b_ext = {1'b0, dvs_reg};
    assign bw[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i <= WIDTH; i++) begin : g_sub
            fullsubtractor u_fs (
                .a   (s[i]),
                .b   (b_ext[i]),
                .bin (bw[i]),
                .diff(t[i]),
                .bout(bw[i+1])
            );
        end
    endgenerate

    // With no final borrow the top difference bit is always 0, so it carries no information.
    assign unused_top_diff = t[WIDTH];

`ifdef DIV_ZERO_CHECK_EN
    logic zero_flag;
    logic dbz_reg;
    assign zero_hit    = zero_flag;
    assign div_by_zero = dbz_reg;
`else
    assign zero_hit    = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (zero_hit || cnt == '0) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_reg <= '0;
            dvs_reg <= '0;
            r_reg   <= '0;
            q_reg   <= '0;
            cnt     <= '0;
`ifdef DIV_ZERO_CHECK_EN
            zero_flag <= 1'b0;
            dbz_reg   <= 1'b0;
`endif
        end else if (state != RUN) begin
            if (start) begin
                dvd_reg <= dividend;
                dvs_reg <= divisor;
                r_reg   <= '0;
                q_reg   <= '0;
                cnt     <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_CHECK_EN
                zero_flag <= (divisor == '0);
                dbz_reg   <= 1'b0;
`endif
            end
        end else begin
`ifdef DIV_ZERO_CHECK_EN
            // A zero divisor spends its single RUN cycle loading the fixed result.
            if (zero_flag) begin
                q_reg   <= '1;
                r_reg   <= dvd_reg;
                dbz_reg <= 1'b1;
            end else
`endif
            begin
                if (!bw[WIDTH+1]) begin
                    r_reg      <= t[WIDTH-1:0];
                    q_reg[cnt] <= 1'b1;
                end else begin
                    r_reg      <= s[WIDTH-1:0];
                    q_reg[cnt] <= 1'b0;
                end
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign quotient  = q_reg;
    assign remainder = r_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: expected results and done cycles are queued
// at issue time and checked by a monitor whenever done pulses.
module tb_restoring_divider;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        logic [31:0]  cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t         exp_q[$];
    int           pass_cnt  = 0;
    int           check_cnt = 0;
    int unsigned  cyc       = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Reference model: plain integer division with the zero-divisor rules.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned accept_edge);
        exp_t e;
        int unsigned lat;
        lat = W;
        if (b == 0) begin
            e.q = {W{1'b1}};
            e.r = a;
`ifdef DIV_ZERO_CHECK_EN
            e.z = 1'b1;
            lat = 1;
`else
            e.z = 1'b0;
`endif
        end else begin
            e.q = W'(int'(a) / int'(b));
            e.r = W'(int'(a) % int'(b));
            e.z = 1'b0;
        end
        e.cyc = accept_edge + lat;
        return e;
    endfunction

    // Driver: called #1 after a rising edge; start is sampled on the next edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) exp_q.push_back(model(a, b, cyc + 1));
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        if (!seen) begin
            check_cnt++;
            $display("FAIL wait_done: got no done, expected done within 40 cycles");
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        send(8'd200, 8'd7, 1);
        check("busy_after_accept", 32'(busy), 1);
        wait_done();
        @(posedge clk); #1;
        send(8'd5, 8'd9, 1);   wait_done(); @(posedge clk); #1;
        send(8'd255, 8'd1, 1); wait_done(); @(posedge clk); #1;
        send(8'd37, 8'd0, 1);  wait_done(); @(posedge clk); #1;

        // Start while busy is ignored
        send(8'd100, 8'd3, 1);
        @(posedge clk); #1;
        send(8'd9, 8'd2, 0);
        wait_done(); @(posedge clk); #1;

        // Reset mid-run discards the operation
        send(8'd200, 8'd7, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_quotient", 32'(quotient), 0);
        check("midrst_remainder", 32'(remainder), 0);
        check("midrst_dbz", 32'(div_by_zero), 0);
        repeat (12) @(posedge clk);
        #1;
        send(8'd50, 8'd5, 1); wait_done();

        // Back-to-back start in the DONE cycle
        send(8'd200, 8'd7, 1); wait_done();
        send(8'd81, 8'd9, 1);
        check("b2b_busy", 32'(busy), 1);
        wait_done(); @(posedge clk); #1;

        // Randomized operations, sometimes back-to-back
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 4));
            send(a, b, 1);
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (15) @(posedge clk);
        #1;
        check("pending_results", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
